// File: rtl/axi_lite_cmd_arbiter_if.sv
// Bundle of requester-side command/response signals and the single-outstanding
// pulse-start / pulse-done master command port shared by the arbiter.
interface axi_lite_cmd_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic                      m_start;
    logic                      m_we;
    logic [ADDR_W-1:0]         m_addr;
    logic [DATA_W-1:0]         m_wdata;
    logic [DATA_W-1:0]         m_rdata;
    logic                      m_done;

    // Arbiter view: it drives the master command port and the requester responses.
    modport master (
        input  req_valid, req_we, req_addr, req_wdata, m_rdata, m_done,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               m_start, m_we, m_addr, m_wdata
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, m_rdata, m_done,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               m_start, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/axi_lite_cmd_arbiter.sv
// Round-robin arbiter sharing one single-outstanding AXI4-Lite command master.
// Optional WAIT watchdog with DRAIN state is enabled by defining ARB_TIMEOUT_EN.
module axi_lite_cmd_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    axi_lite_cmd_arbiter_if.master bus
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DRAIN = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;
`endif

    state_t              state_reg, state_next;
    logic [GW-1:0]       grant_reg, grant_next;
    logic [GW-1:0]       last_grant_reg, last_grant_next;
    logic [NUM_REQ-1:0]  req_ready_reg, req_ready_next;
    logic [NUM_REQ-1:0]  rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0]   rsp_rdata_reg, rsp_rdata_next;
    logic                m_start_reg, m_start_next;
    logic                m_we_reg, m_we_next;
    logic [ADDR_W-1:0]   m_addr_reg, m_addr_next;
    logic [DATA_W-1:0]   m_wdata_reg, m_wdata_next;
`ifdef ARB_TIMEOUT_EN
    logic                rsp_err_reg, rsp_err_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
`endif

    logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [DATA_W-1:0] wdata_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Round-robin pick: first pending requester after the previous winner, with wrap.
    logic          found;
    logic [GW-1:0] sel;
    logic [GW-1:0] sel_try;
    int            idx;

    always_comb begin
        found   = 1'b0;
        sel     = '0;
        sel_try = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx     = (int'(last_grant_reg) + k) % NUM_REQ;
            sel_try = GW'(idx);
            if (!found && bus.req_valid[sel_try]) begin
                found = 1'b1;
                sel   = sel_try;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        req_ready_next  = '0;
        rsp_valid_next  = '0;
        rsp_rdata_next  = rsp_rdata_reg;
        m_start_next    = 1'b0;
        m_we_next       = m_we_reg;
        m_addr_next     = m_addr_reg;
        m_wdata_next    = m_wdata_reg;
`ifdef ARB_TIMEOUT_EN
        rsp_err_next    = 1'b0;
        cnt_next        = cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (found) begin
                    grant_next      = sel;
                    last_grant_next = sel;
                    m_we_next       = bus.req_we[sel];
                    m_addr_next     = addr_arr[sel];
                    m_wdata_next    = wdata_arr[sel];
                    m_start_next    = 1'b1;
                    req_ready_next  = NUM_REQ'(1) << sel;
                    state_next      = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
`ifdef ARB_TIMEOUT_EN
                cnt_next   = '0;
`endif
            end
            WAIT: begin
                if (bus.m_done) begin
                    rsp_rdata_next = bus.m_rdata;
                    rsp_valid_next = NUM_REQ'(1) << grant_reg;
                    state_next     = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_reg == CW'(TIMEOUT_CYCLES - 1)) begin
                    // Answer the requester now; the late completion is swallowed in DRAIN.
                    rsp_rdata_next = '1;
                    rsp_valid_next = NUM_REQ'(1) << grant_reg;
                    rsp_err_next   = 1'b1;
                    state_next     = DRAIN;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
`endif
            end
`ifdef ARB_TIMEOUT_EN
            DRAIN: begin
                if (bus.m_done) begin
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= GW'(NUM_REQ - 1);
            req_ready_reg  <= '0;
            rsp_valid_reg  <= '0;
            rsp_rdata_reg  <= '0;
            m_start_reg    <= 1'b0;
            m_we_reg       <= 1'b0;
            m_addr_reg     <= '0;
            m_wdata_reg    <= '0;
`ifdef ARB_TIMEOUT_EN
            rsp_err_reg    <= 1'b0;
            cnt_reg        <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            req_ready_reg  <= req_ready_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_rdata_reg  <= rsp_rdata_next;
            m_start_reg    <= m_start_next;
            m_we_reg       <= m_we_next;
            m_addr_reg     <= m_addr_next;
            m_wdata_reg    <= m_wdata_next;
`ifdef ARB_TIMEOUT_EN
            rsp_err_reg    <= rsp_err_next;
            cnt_reg        <= cnt_next;
`endif
        end
    end

    assign bus.req_ready = req_ready_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.m_start   = m_start_reg;
    assign bus.m_we      = m_we_reg;
    assign bus.m_addr    = m_addr_reg;
    assign bus.m_wdata   = m_wdata_reg;
`ifdef ARB_TIMEOUT_EN
    assign bus.rsp_err   = rsp_err_reg;
`else
    assign bus.rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_axi_lite_cmd_arbiter.sv
// Directed self-checking bench for axi_lite_cmd_arbiter; the watchdog section
// only runs when ARB_TIMEOUT_EN is defined.
module tb_axi_lite_cmd_arbiter;
    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_lite_cmd_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    axi_lite_cmd_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("check %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.req_we[i]            = we;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ready"}, bus.req_ready, 4'b0000);
        check({tag, "_rspv"},  bus.rsp_valid, 4'b0000);
        check({tag, "_err"},   bus.rsp_err, 1'b0);
        check({tag, "_start"}, bus.m_start, 1'b0);
        check({tag, "_we"},    bus.m_we, 1'b0);
        check({tag, "_addr"},  bus.m_addr, 32'h0);
        check({tag, "_wdata"}, bus.m_wdata, 32'h0);
        check({tag, "_rdata"}, bus.rsp_rdata, 32'h0);
    endtask

    task automatic wait_start(input string tag);
        for (int k = 0; k < 40 && !bus.m_start; k++) @(negedge clk);
        check({tag, "_start"}, bus.m_start, 1'b1);
    endtask

    // One full transaction: expect requester g to win, complete it one cycle later.
    task automatic run_txn(input int g, input logic [31:0] rdata, input bit drop, input string tag);
        logic [3:0] oh;
        oh = 4'(1) << g;
        wait_start(tag);
        check({tag, "_ready"}, bus.req_ready, oh);
        check({tag, "_addr"},  bus.m_addr, bus.req_addr[g*AW +: AW]);
        check({tag, "_mwe"},   bus.m_we, bus.req_we[g]);
        $display("txn %s: grant=%0d addr=0x%0h we=%0d", tag, g, bus.m_addr, bus.m_we);
        if (drop) bus.req_valid[g] = 1'b0;
        @(negedge clk);
        check({tag, "_pulse1"}, bus.m_start, 1'b0);
        bus.m_done  = 1'b1;
        bus.m_rdata = rdata;
        @(negedge clk);
        bus.m_done = 1'b0;
        check({tag, "_rspv"},  bus.rsp_valid, oh);
        check({tag, "_rdata"}, bus.rsp_rdata, rdata);
        check({tag, "_err"},   bus.rsp_err, 1'b0);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.m_rdata   = '0;
        bus.m_done    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single write from requester 1, master done 5 cycles after start
        set_req(1, 1'b1, 32'h40, 32'hDEADBEEF);
        bus.req_valid = 4'b0010;
        @(negedge clk);
        check("wr_start", bus.m_start, 1'b1);
        check("wr_ready", bus.req_ready, 4'b0010);
        check("wr_addr",  bus.m_addr, 32'h40);
        check("wr_wdata", bus.m_wdata, 32'hDEADBEEF);
        check("wr_we",    bus.m_we, 1'b1);
        $display("txn write1: addr=0x%0h wdata=0x%0h", bus.m_addr, bus.m_wdata);
        bus.req_valid = 4'b0000;
        @(negedge clk);
        check("wr_pulse", bus.m_start, 1'b0);
        check("wr_ready_pulse", bus.req_ready, 4'b0000);
        repeat (3) @(negedge clk);
        check("wr_nodone", bus.rsp_valid, 4'b0000);
        check("wr_hold_addr", bus.m_addr, 32'h40);
        @(negedge clk);
        bus.m_done = 1'b1;
        @(negedge clk);
        bus.m_done = 1'b0;
        check("wr_rspv", bus.rsp_valid, 4'b0010);
        @(negedge clk);
        check("wr_rspv_pulse", bus.rsp_valid, 4'b0000);

        // Stray m_done while IDLE must be ignored
        bus.m_done = 1'b1;
        @(negedge clk);
        bus.m_done = 1'b0;
        check("stray_rspv", bus.rsp_valid, 4'b0000);
        check("stray_start", bus.m_start, 1'b0);

        // Read routing to requester 3
        set_req(3, 1'b0, 32'h100, 32'h0);
        bus.req_valid = 4'b1000;
        run_txn(3, 32'h12345678, 1'b1, "read3");
        @(negedge clk);
        check("read3_rspv_pulse", bus.rsp_valid, 4'b0000);

        // Contention from reset: 0,1,2,3,0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, i[0], 32'h1000 + 32'(i*4), 32'hA0 + 32'(i));
        bus.req_valid = 4'b1111;
        run_txn(0, 32'h11110000, 1'b0, "rr0");
        run_txn(1, 32'h11110001, 1'b0, "rr1");
        run_txn(2, 32'h11110002, 1'b0, "rr2");
        run_txn(3, 32'h11110003, 1'b0, "rr3");
        run_txn(0, 32'h11110004, 1'b0, "rr4");
        bus.req_valid = 4'b0000;

        // Fairness: req0 continuous, req2 joins after first grant
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 4'b0001;
        run_txn(0, 32'h22220000, 1'b0, "fair0");
        bus.req_valid[2] = 1'b1;
        run_txn(2, 32'h22220001, 1'b0, "fair1");
        run_txn(0, 32'h22220002, 1'b0, "fair2");
        run_txn(2, 32'h22220003, 1'b0, "fair3");
        bus.req_valid = 4'b0000;

        // Reset in the middle of WAIT, then tie between 0 and 3
        @(negedge clk);
        bus.req_valid = 4'b0010;
        wait_start("mid");
        bus.req_valid = 4'b0000;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_quiet("midrst");
        rst = 1'b0;
        bus.req_valid = 4'b1001;
        run_txn(0, 32'h33330000, 1'b0, "post0");
        run_txn(3, 32'h33330003, 1'b0, "post3");
        bus.req_valid = 4'b0000;

`ifdef ARB_TIMEOUT_EN
        begin
            int  cycles;
            bit  early;
            @(negedge clk);
            bus.req_valid = 4'b0010;
            wait_start("to");
            bus.req_valid = 4'b0000;
            cycles = 0;
            while (!bus.rsp_valid[1] && cycles < 60) begin
                @(negedge clk);
                cycles++;
            end
            check("to_cycles", 64'(cycles), 64'(TO + 1));
            check("to_rspv",   bus.rsp_valid, 4'b0010);
            check("to_err",    bus.rsp_err, 1'b1);
            check("to_rdata",  bus.rsp_rdata, 32'hFFFFFFFF);
            $display("txn timeout: cycles=%0d err=%0d", cycles, bus.rsp_err);
            bus.req_valid = 4'b1000;
            early = 1'b0;
            repeat (6) begin
                @(negedge clk);
                if (bus.m_start) early = 1'b1;
            end
            check("drain_block", early, 1'b0);
            bus.m_done = 1'b1;
            @(negedge clk);
            bus.m_done = 1'b0;
            check("drain_idle", bus.m_start, 1'b0);
            run_txn(3, 32'h44440003, 1'b1, "late3");
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axi_lite_cmd_arbiter.md
Name: axi_lite_cmd_arbiter

Overview:
Round-robin arbiter that shares one single-outstanding AXI4-Lite master command port among NUM_REQ requesters. The master port is a pulse-start / pulse-done interface.
- Latches the winning requester's command and issues it downstream.
- Waits for completion, then routes the done pulse and read data back to the winner.
- Sits between CPU/DMA-side clients and the AXI4-Lite master in the peripheral-access path.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT_CYCLES, 1024, watchdog limit in WAIT (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
req_valid  in  NUM_REQ  per-requester command pending; hold with stable payload until req_ready
req_we  in  NUM_REQ  per-requester 1=write, 0=read
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_ready  out  NUM_REQ  one-hot one-cycle accept pulse
rsp_valid  out  NUM_REQ  one-hot one-cycle completion pulse
rsp_rdata  out  DATA_W  read data for current rsp_valid; shared bus
rsp_err  out  1  timeout flag qualified by rsp_valid (tied 0 without ARB_TIMEOUT_EN)
m_start  out  1  one-cycle start pulse to master
m_we  out  1  write enable to master
m_addr  out  ADDR_W  address to master
m_wdata  out  DATA_W  write data to master
m_rdata  in  DATA_W  read data from master, valid with m_done
m_done  in  1  master completion pulse

Behaviour:
- All outputs registered.
- Reset values:
  - req_ready, rsp_valid, rsp_err, m_start, m_we: 0
  - m_addr, m_wdata, rsp_rdata: 0
  - state IDLE
  - last_grant = NUM_REQ-1, so requester 0 wins first.
- States:
  - IDLE: if any req_valid at edge t, select winner g = first set bit searching from (last_grant+1) mod NUM_REQ upward with wrap. Latch g, req_we[g], req_addr[g], req_wdata[g] into m_we/m_addr/m_wdata; last_grant <= g; go ISSUE. No request: stay IDLE, outputs hold.
  - ISSUE (exactly one cycle): m_start=1 and req_ready[g]=1 in this same cycle; go WAIT.
  - WAIT: m_addr/m_we/m_wdata held stable. On m_done: rsp_rdata <= m_rdata (writes capture as well; value don't-care), rsp_valid[g]=1 next cycle, go IDLE.
- Latency:
  - req_valid sampled → req_ready/m_start one cycle later.
  - m_done → rsp_valid one cycle later.
  - The cycle rsp_valid is high is an IDLE cycle and may arbitrate the next request. Back-to-back spacing: 2 cycles + master latency.
- Boundary conditions:
  - m_done outside WAIT is ignored.
  - req_valid dropping after a grant has no effect; the command is already latched.
  - A requester may re-assert req_valid in the cycle after its req_ready.
  - A single continuous requester is granted every transaction; contending requesters alternate strictly.
  - Only one transaction outstanding at any time.
  - Reset mid-transaction returns to IDLE with all pulses low. Master reset is shared, so no drain is needed.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- With it: a counter clears on entering WAIT and increments each WAIT cycle. On reaching TIMEOUT_CYCLES without m_done: rsp_valid[g]=1, rsp_err=1, rsp_rdata=all-ones; then go to state DRAIN.
- DRAIN: stays there until m_done, discards the late completion, goes IDLE. No arbitration in DRAIN.
- Without it: no counter, no DRAIN state, rsp_err tied 0, and WAIT waits indefinitely.

Test Plan:
- Single write: req_valid[1]=1, we=1, addr=0x40, wdata=0xDEADBEEF → next cycle m_start=1, req_ready=4'b0010, m_addr=0x40, m_wdata=0xDEADBEEF. Master done after 5 cycles → rsp_valid=4'b0010 one cycle later.
- Read routing: req 3 reads 0x100, master returns m_rdata=0x12345678 → rsp_valid=4'b1000, rsp_rdata=0x12345678, rsp_err=0.
- Contention: all four req_valid held from reset → grant order 0,1,2,3,0 with exactly one m_start per transaction and no overlap.
- Fairness: req0 held continuously, req2 asserted after first grant → grants 0,2,0,2; req0 never granted twice in a row while req2 is pending.
- Reset mid-WAIT: assert rst while waiting → all outputs 0 and state IDLE. The next request after release issues normally, with requester 0 winning a tie.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16: master never signals done → rsp_valid with rsp_err=1 and rdata=0xFFFFFFFF at 16 cycles. A pending request is not issued until a late m_done arrives; it then issues the cycle after.
